sm_divrem: RTL

SM_DIVREM -- requirements
Module: sm_divrem

---
 rtl/sm_divrem.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sm_divrem.sv
// Sequential signed-magnitude divider: restoring division on the magnitudes, one quotient
// bit per cycle, then a single fix-up cycle for signs and the optional floored correction.
module sm_divrem #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] numerator,
  input  logic [WIDTH-1:0] denominator,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divbyzero,
  output logic             zero
);

  localparam int unsigned M    = WIDTH - 1;
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StDiv, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [M-1:0]      num_q, num_d;
  logic [M-1:0]      den_q, den_d;
  logic [M-1:0]      rem_q, rem_d;
  logic [M-1:0]      quo_q, quo_d;
  logic              nsign_q, nsign_d;
  logic              dsign_q, dsign_d;
  logic              mode_q, mode_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  quotient_q, quotient_d;
  logic [WIDTH-1:0]  remainder_q, remainder_d;
  logic              divbyzero_q, divbyzero_d;
  logic              zero_q, zero_d;

  logic [M:0]   trial, diff;
  logic         fits, sdiff, corr;
  logic [M-1:0] qmag, rmag;

  always_comb begin
    // Restoring step: bring down the next numerator bit and subtract when the divisor fits.
    trial = {rem_q, num_q[M-1]};
    diff  = trial - {1'b0, den_q};
    fits  = trial >= {1'b0, den_q};
    sdiff = nsign_q ^ dsign_q;
    corr  = mode_q & sdiff & (rem_q != '0);
    qmag  = quo_q + M'(corr);
    rmag  = corr ? (den_q - rem_q) : rem_q;

    state_d     = state_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    den_d       = den_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    nsign_d     = nsign_q;
    dsign_d     = dsign_q;
    mode_d      = mode_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    divbyzero_d = divbyzero_q;
    zero_d      = zero_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          nsign_d = numerator[M];
          dsign_d = denominator[M];
          num_d   = numerator[M-1:0];
          den_d   = denominator[M-1:0];
          mode_d  = mode;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          if (denominator[M-1:0] == '0) begin
            state_d     = StDone;
            done_d      = 1'b1;
            quotient_d  = '0;
            remainder_d = '0;
            divbyzero_d = 1'b1;
            zero_d      = 1'b1;
          end else begin
            state_d = StDiv;
          end
        end
      end
      StDiv: begin
        rem_d = fits ? diff[M-1:0] : trial[M-1:0];
        quo_d = {quo_q[M-2:0], fits};
        num_d = {num_q[M-2:0], 1'b0};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(M - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d     = StDone;
        done_d      = 1'b1;
        // Zero magnitudes always carry a positive sign.
        quotient_d  = {sdiff & (qmag != '0), qmag};
        remainder_d = {(mode_q ? dsign_q : nsign_q) & (rmag != '0), rmag};
        divbyzero_d = 1'b0;
        zero_d      = (rmag == '0);
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      num_q       <= '0;
      den_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      nsign_q     <= 1'b0;
      dsign_q     <= 1'b0;
      mode_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      divbyzero_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      den_q       <= den_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      nsign_q     <= nsign_d;
      dsign_q     <= dsign_d;
      mode_q      <= mode_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      divbyzero_q <= divbyzero_d;
      zero_q      <= zero_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign divbyzero = divbyzero_q;
  assign zero      = zero_q;

endmodule
